pe_mp_v2: RTL and testbench

- Second-generation weight-stationary systolic PE with a parametrised datapath and a multi-precision MAC.
- A WBUF_DEPTH-deep queue of preloaded weights sits behind the active weight, so several tiles can be staged ahead of use; each queued weight carries its own precision mode.
- Accumulation optionally saturates, with sticky overflow and weight-queue error flags.
- Tiles into the systolic array exactly as the current PE does: psum north to south, activations west to east.

---
 rtl/pe_mp_v2.sv | 229 ++++++++++++++++++++++
 tb/tb_pe_mp_v2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pe_mp_v2.sv
// pe_mp_v2 - weight-stationary systolic processing element, multi-precision MAC.
//
// A WBUF_DEPTH-deep circular queue of {weight, mode} pairs is staged behind the
// active weight. A switch pops the queue head into the active slot, and the MAC
// on that same cycle already uses the popped weight. Partial sums flow north to
// south, and activations flow west to east. Every output is registered.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   pe_psum_in          signed partial sum from north (ACC_WIDTH)
//   pe_weight_in        weight from north (DATA_WIDTH)
//   pe_accept_w_in      enqueue pe_weight_in together with sys_mode
//   sys_mode            precision mode tag for the enqueued weight
//   pe_input_in         activation from west (DATA_WIDTH)
//   pe_valid_in         activation valid
//   pe_switch_in        promote queue head to active
//   pe_enabled          0 = freeze all state
//   clr_flags           clear sticky flags
//   pe_psum_out         partial sum to south
//   pe_weight_out       weight forwarded south (0 when not accepted)
//   pe_accept_w_out     accept forwarded south
//   pe_mode_out         mode forwarded south (0 when not accepted)
//   pe_input_out        activation to east
//   pe_valid_out        activation valid to east
//   pe_switch_out       switch forwarded
//   active_mode         mode of the active weight
//   wbuf_count          number of queued weights
//   ovf_sticky          accumulation overflow seen
//   wbuf_err            queue overflow or underflow seen
//
// Modes: 00 signed x signed, 01 unsigned act x signed weight,
//        10 2-lane signed dot product, 11 4-lane signed dot product.
module pe_mp_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int WBUF_DEPTH = 2,
    parameter int SATURATE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_WIDTH-1:0]          pe_psum_in,
    input  logic [DATA_WIDTH-1:0]         pe_weight_in,
    input  logic                          pe_accept_w_in,
    input  logic [1:0]                    sys_mode,
    input  logic [DATA_WIDTH-1:0]         pe_input_in,
    input  logic                          pe_valid_in,
    input  logic                          pe_switch_in,
    input  logic                          pe_enabled,
    input  logic                          clr_flags,
    output logic [ACC_WIDTH-1:0]          pe_psum_out,
    output logic [DATA_WIDTH-1:0]         pe_weight_out,
    output logic                          pe_accept_w_out,
    output logic [1:0]                    pe_mode_out,
    output logic [DATA_WIDTH-1:0]         pe_input_out,
    output logic                          pe_valid_out,
    output logic                          pe_switch_out,
    output logic [1:0]                    active_mode,
    output logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_count,
    output logic                          ovf_sticky,
    output logic                          wbuf_err
);

    localparam int CW = $clog2(WBUF_DEPTH + 1);
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int HW = DATA_WIDTH / 2;
    localparam int QW = DATA_WIDTH / 4;
    localparam int XW = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Queue storage and pointers
    logic [DATA_WIDTH-1:0] wq_w_q [WBUF_DEPTH];
    logic [1:0]            wq_m_q [WBUF_DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    // Active weight
    logic [DATA_WIDTH-1:0] act_w_q;
    logic [1:0]            act_m_q;

    // Registered outputs
    logic [ACC_WIDTH-1:0]  psum_q, psum_d;
    logic [DATA_WIDTH-1:0] wout_q;
    logic                  accout_q;
    logic [1:0]            mout_q;
    logic [DATA_WIDTH-1:0] inout_q;
    logic                  vout_q;
    logic                  swout_q;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;

    logic                  q_empty, q_full;
    logic                  pop_ok, push_ok, err_set;
    logic [DATA_WIDTH-1:0] eff_w;
    logic [1:0]            eff_m;

    logic signed [2*DATA_WIDTH-1:0] p00;
    logic signed [2*DATA_WIDTH:0]   p01;
    logic signed [DATA_WIDTH-1:0]   lp2;
    logic signed [HW-1:0]           lp4;
    logic signed [XW-1:0]           prod_x, sum_x;
    logic                           ovf_raw;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Push and pop are both judged against the pre-edge count, so a pop on a
    // full queue makes room for a push in the same cycle.
    always_comb begin
        q_empty = (count_q == '0);
        q_full  = (count_q == CW'(WBUF_DEPTH));
        pop_ok  = pe_switch_in && !q_empty;
        push_ok = pe_accept_w_in && (!q_full || pop_ok);
        err_set = (pe_switch_in && q_empty) ||
                  (pe_accept_w_in && q_full && !pe_switch_in);
        head_d  = pop_ok  ? ptr_inc(head_q) : head_q;
        tail_d  = push_ok ? ptr_inc(tail_q) : tail_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        eff_w = pop_ok ? wq_w_q[head_q] : act_w_q;
        eff_m = pop_ok ? wq_m_q[head_q] : act_m_q;
    end

    // Multi-precision MAC. Every product is widened to ACC_WIDTH+1 before the
    // psum add, so overflow shows up as disagreement of the top two bits.
    always_comb begin
        p00    = $signed(pe_input_in) * $signed(eff_w);
        p01    = $signed({1'b0, pe_input_in}) * $signed(eff_w);
        prod_x = '0;
        lp2    = '0;
        lp4    = '0;
        case (eff_m)
            2'b00: prod_x = XW'(p00);
            2'b01: prod_x = XW'(p01);
            2'b10: begin
                for (int i = 0; i < 2; i++) begin
                    lp2    = $signed(pe_input_in[i*HW +: HW]) * $signed(eff_w[i*HW +: HW]);
                    prod_x = prod_x + XW'(lp2);
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    lp4    = $signed(pe_input_in[i*QW +: QW]) * $signed(eff_w[i*QW +: QW]);
                    prod_x = prod_x + XW'(lp4);
                end
            end
        endcase
        sum_x   = prod_x + XW'($signed(pe_psum_in));
        ovf_raw = (sum_x[XW-1] != sum_x[XW-2]);
        if (ovf_raw && (SATURATE != 0))
            psum_d = sum_x[XW-1] ? ACC_MIN : ACC_MAX;
        else
            psum_d = sum_x[ACC_WIDTH-1:0];
    end

    // A set in the same cycle as clr_flags leaves the flag set.
    always_comb begin
        ovf_d = (ovf_q & ~clr_flags) | (pe_valid_in & ovf_raw);
        err_d = (err_q & ~clr_flags) | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wq_w_q[i] <= '0;
                wq_m_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            act_w_q  <= '0;
            act_m_q  <= '0;
            psum_q   <= '0;
            wout_q   <= '0;
            accout_q <= 1'b0;
            mout_q   <= '0;
            inout_q  <= '0;
            vout_q   <= 1'b0;
            swout_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (pe_enabled) begin
            if (push_ok) begin
                wq_w_q[tail_q] <= pe_weight_in;
                wq_m_q[tail_q] <= sys_mode;
            end
            if (pop_ok) begin
                act_w_q <= eff_w;
                act_m_q <= eff_m;
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wout_q   <= pe_accept_w_in ? pe_weight_in : '0;
            mout_q   <= pe_accept_w_in ? sys_mode : 2'b00;
            accout_q <= pe_accept_w_in;
            swout_q  <= pe_switch_in;
            psum_q   <= pe_valid_in ? psum_d : '0;
            inout_q  <= pe_valid_in ? pe_input_in : '0;
            vout_q   <= pe_valid_in;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end else begin
            // Frozen: only the pulse-type outputs drop; everything else holds.
            vout_q   <= 1'b0;
            swout_q  <= 1'b0;
            accout_q <= 1'b0;
        end
    end

    assign pe_psum_out     = psum_q;
    assign pe_weight_out   = wout_q;
    assign pe_accept_w_out = accout_q;
    assign pe_mode_out     = mout_q;
    assign pe_input_out    = inout_q;
    assign pe_valid_out    = vout_q;
    assign pe_switch_out   = swout_q;
    assign active_mode     = act_m_q;
    assign wbuf_count      = count_q;
    assign ovf_sticky      = ovf_q;
    assign wbuf_err        = err_q;

endmodule

// File: tb/tb_pe_mp_v2.sv
// tb_pe_mp_v2 - directed, table-driven bench for pe_mp_v2 (default parameters).
// Each record is one clock: inputs are applied, then every output is compared
// one time unit after the rising edge.
module tb_pe_mp_v2;

    logic        clk;
    logic        rst;
    logic [31:0] pe_psum_in;
    logic [15:0] pe_weight_in;
    logic        pe_accept_w_in;
    logic [1:0]  sys_mode;
    logic [15:0] pe_input_in;
    logic        pe_valid_in;
    logic        pe_switch_in;
    logic        pe_enabled;
    logic        clr_flags;
    logic [31:0] pe_psum_out;
    logic [15:0] pe_weight_out;
    logic        pe_accept_w_out;
    logic [1:0]  pe_mode_out;
    logic [15:0] pe_input_out;
    logic        pe_valid_out;
    logic        pe_switch_out;
    logic [1:0]  active_mode;
    logic [1:0]  wbuf_count;
    logic        ovf_sticky;
    logic        wbuf_err;

    pe_mp_v2 dut (
        .clk             (clk),
        .rst             (rst),
        .pe_psum_in      (pe_psum_in),
        .pe_weight_in    (pe_weight_in),
        .pe_accept_w_in  (pe_accept_w_in),
        .sys_mode        (sys_mode),
        .pe_input_in     (pe_input_in),
        .pe_valid_in     (pe_valid_in),
        .pe_switch_in    (pe_switch_in),
        .pe_enabled      (pe_enabled),
        .clr_flags       (clr_flags),
        .pe_psum_out     (pe_psum_out),
        .pe_weight_out   (pe_weight_out),
        .pe_accept_w_out (pe_accept_w_out),
        .pe_mode_out     (pe_mode_out),
        .pe_input_out    (pe_input_out),
        .pe_valid_out    (pe_valid_out),
        .pe_switch_out   (pe_switch_out),
        .active_mode     (active_mode),
        .wbuf_count      (wbuf_count),
        .ovf_sticky      (ovf_sticky),
        .wbuf_err        (wbuf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, acc;
        logic [15:0] w;
        logic [1:0]  m;
        logic        sw, vld;
        logic [15:0] inp;
        logic [31:0] psum;
        logic        clr;
        logic [31:0] e_psum;
        logic        e_vld;
        logic [15:0] e_inp, e_wout;
        logic        e_acc;
        logic [1:0]  e_mode;
        logic        e_sw;
        logic [1:0]  e_amode, e_cnt;
        logic        e_ovf, e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic rst_v, en, acc, input logic [15:0] w, input logic [1:0] m,
                       input logic sw, vld, input logic [15:0] inp, input logic [31:0] psum,
                       input logic clr, input logic [31:0] ep, input logic ev,
                       input logic [15:0] ei, ew, input logic ea, input logic [1:0] em,
                       input logic es, input logic [1:0] eam, ec, input logic eo, ee);
        vec_t v;
        v.rst = rst_v; v.en = en; v.acc = acc; v.w = w; v.m = m; v.sw = sw; v.vld = vld;
        v.inp = inp; v.psum = psum; v.clr = clr;
        v.e_psum = ep; v.e_vld = ev; v.e_inp = ei; v.e_wout = ew; v.e_acc = ea;
        v.e_mode = em; v.e_sw = es; v.e_amode = eam; v.e_cnt = ec; v.e_ovf = eo; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; pe_enabled = v.en; pe_accept_w_in = v.acc; pe_weight_in = v.w;
        sys_mode = v.m; pe_switch_in = v.sw; pe_valid_in = v.vld; pe_input_in = v.inp;
        pe_psum_in = v.psum; clr_flags = v.clr;
        @(posedge clk);
        #1;
        n_vec++;
        chk(idx, "psum_out",    pe_psum_out,            v.e_psum);
        chk(idx, "valid_out",   32'(pe_valid_out),      32'(v.e_vld));
        chk(idx, "input_out",   32'(pe_input_out),      32'(v.e_inp));
        chk(idx, "weight_out",  32'(pe_weight_out),     32'(v.e_wout));
        chk(idx, "accept_out",  32'(pe_accept_w_out),   32'(v.e_acc));
        chk(idx, "mode_out",    32'(pe_mode_out),       32'(v.e_mode));
        chk(idx, "switch_out",  32'(pe_switch_out),     32'(v.e_sw));
        chk(idx, "active_mode", 32'(active_mode),       32'(v.e_amode));
        chk(idx, "wbuf_count",  32'(wbuf_count),        32'(v.e_cnt));
        chk(idx, "ovf_sticky",  32'(ovf_sticky),        32'(v.e_ovf));
        chk(idx, "wbuf_err",    32'(wbuf_err),          32'(v.e_err));
    endtask

    initial begin
        vec_t hv;
        rst = 1'b1; pe_enabled = 1'b1; pe_accept_w_in = 1'b0; pe_weight_in = '0;
        sys_mode = '0; pe_switch_in = 1'b0; pe_valid_in = 1'b0; pe_input_in = '0;
        pe_psum_in = '0; clr_flags = 1'b0;

        //   rst en acc w        m sw vld inp      psum         clr | psum         v  inp      wout     a  m  s  am c  o  e
        // reset with stimulus active
        add(1, 1, 1, 'h1234, 3, 1, 1, 'h5555, 100,         0,   0,           0, 0,       0,       0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 'h1234, 3, 1, 1, 'h5555, 100,         0,   0,           0, 0,       0,       0, 0, 0, 0, 0, 0, 0);
        // modes 00 / 01, switch cycle uses the popped weight
        add(0, 1, 1, 'h0003, 0, 0, 0, 0,      0,           0,   0,           0, 0,       'h0003,  1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'h0005, 10,          0,   25,          1, 'h0005,  0,       0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 'h0002, 1, 0, 0, 0,      0,           0,   0,           0, 0,       'h0002,  1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'hFFFF, 0,           0,   131070,      1, 'hFFFF,  0,       0, 0, 1, 1, 0, 0, 0);
        // packed modes
        add(0, 1, 1, 'h02FF, 2, 0, 0, 0,      0,           0,   0,           0, 0,       'h02FF,  1, 2, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'h0304, 0,           0,   2,           1, 'h0304,  0,       0, 0, 1, 2, 0, 0, 0);
        add(0, 1, 1, 'h1111, 3, 0, 0, 0,      0,           0,   0,           0, 0,       'h1111,  1, 3, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'hF234, 0,           0,   8,           1, 'hF234,  0,       0, 0, 1, 3, 0, 0, 0);
        add(0, 1, 0, 0,      0, 0, 1, 'h0002, 1,           0,   3,           1, 'h0002,  0,       0, 0, 0, 3, 0, 0, 0);
        // queue limits: overflow drop, drain, underflow, clear
        add(0, 1, 1, 'h0007, 0, 0, 0, 0,      0,           0,   0,           0, 0,       'h0007,  1, 0, 0, 3, 1, 0, 0);
        add(0, 1, 1, 'h0009, 1, 0, 0, 0,      0,           0,   0,           0, 0,       'h0009,  1, 1, 0, 3, 2, 0, 0);
        add(0, 1, 1, 'h000B, 2, 0, 0, 0,      0,           0,   0,           0, 0,       'h000B,  1, 2, 0, 3, 2, 0, 1);
        add(0, 1, 0, 0,      0, 1, 0, 0,      0,           0,   0,           0, 0,       0,       0, 0, 1, 0, 1, 0, 1);
        add(0, 1, 0, 0,      0, 1, 1, 3,      0,           0,   27,          1, 3,       0,       0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 0,      0, 1, 1, 2,      0,           0,   18,          1, 2,       0,       0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 0,      0, 0, 0, 0,      0,           1,   0,           0, 0,       0,       0, 0, 0, 1, 0, 0, 0);
        // push+pop on full queue, then push+pop on empty queue
        add(0, 1, 1, 4,      0, 0, 0, 0,      0,           0,   0,           0, 0,       4,       1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 5,      0, 0, 0, 0,      0,           0,   0,           0, 0,       5,       1, 0, 0, 1, 2, 0, 0);
        add(0, 1, 1, 6,      1, 1, 1, 10,     0,           0,   40,          1, 10,      6,       1, 1, 1, 0, 2, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 1,      0,           0,   5,           1, 1,       0,       0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'hFFFF, 0,           0,   'h0005FFFA,  1, 'hFFFF,  0,       0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 8,      0, 1, 1, 2,      0,           0,   12,          1, 2,       8,       1, 0, 1, 1, 1, 0, 1);
        add(0, 1, 0, 0,      0, 1, 1, 3,      0,           1,   24,          1, 3,       0,       0, 0, 1, 0, 0, 0, 0);
        // saturation positive / negative, set wins over clear
        add(0, 1, 1, 'h0100, 0, 0, 0, 0,      0,           0,   0,           0, 0,       'h0100,  1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'h0100, 'h7FFFFFF0,  0,   'h7FFFFFFF,  1, 'h0100,  0,       0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 'hFF00, 0, 0, 0, 0,      0,           0,   0,           0, 0,       'hFF00,  1, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0,      0, 1, 1, 'h0100, 'h80000010,  0,   'h80000000,  1, 'h0100,  0,       0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0,      0, 0, 1, 'h0100, 'h80000010,  1,   'h80000000,  1, 'h0100,  0,       0, 0, 0, 0, 0, 1, 0);
        // freeze mid-stream for 3 cycles, then resume
        add(0, 1, 1, 3,      0, 0, 0, 0,      0,           0,   0,           0, 0,       3,       1, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0,      0, 0, 1, 4,      5,           0,   'hFFFFFC05,  1, 4,       0,       0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 'h00AA, 2, 1, 1, 7,      99,          1,   'hFFFFFC05,  0, 4,       0,       0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 'h00AA, 2, 1, 1, 7,      99,          1,   'hFFFFFC05,  0, 4,       0,       0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 'h00AA, 2, 1, 1, 7,      99,          1,   'hFFFFFC05,  0, 4,       0,       0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0,      0, 0, 1, 4,      5,           0,   'hFFFFFC05,  1, 4,       0,       0, 0, 0, 0, 1, 1, 0);
        // reset with queued weights discards everything
        add(0, 1, 1, 5,      1, 0, 0, 0,      0,           0,   0,           0, 0,       5,       1, 1, 0, 0, 2, 1, 0);
        add(1, 1, 1, 5,      1, 1, 1, 3,      7,           0,   0,           0, 0,       0,       0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,      0, 0, 1, 3,      7,           0,   7,           1, 3,       0,       0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Hand-written: same weight/activation bits, signed vs unsigned activation.
        hv = vecs[vecs.size()-1];
        hv.rst = 0; hv.en = 1; hv.clr = 0; hv.psum = 0;
        hv.acc = 1; hv.w = 'hFFFF; hv.m = 0; hv.sw = 0; hv.vld = 0; hv.inp = 0;
        hv.e_psum = 0; hv.e_vld = 0; hv.e_inp = 0; hv.e_wout = 'hFFFF; hv.e_acc = 1;
        hv.e_mode = 0; hv.e_sw = 0; hv.e_amode = 0; hv.e_cnt = 1; hv.e_ovf = 0; hv.e_err = 0;
        run_vec(hv, 100);
        hv.m = 1; hv.e_mode = 1; hv.e_cnt = 2;
        run_vec(hv, 101);
        hv.acc = 0; hv.sw = 1; hv.vld = 1; hv.inp = 'hFFFF;
        hv.e_psum = 1; hv.e_vld = 1; hv.e_inp = 'hFFFF; hv.e_wout = 0; hv.e_acc = 0;
        hv.e_mode = 0; hv.e_sw = 1; hv.e_amode = 0; hv.e_cnt = 1;
        run_vec(hv, 102);
        hv.e_psum = 'hFFFF0001; hv.e_amode = 1; hv.e_cnt = 0;
        run_vec(hv, 103);
        // Switch on the now-empty queue: underflow keeps the mode-01 weight.
        hv.e_err = 1;
        run_vec(hv, 104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
